// File: rtl/gcd_client.sv
// gcd_client: request-side initiator for the single-problem GCD unit.
// Host commands (A,B) are queued in a DEPTH-entry FIFO and issued one at a
// time; each result is returned to the host together with its operands.
// Optional build macro GCD_CLIENT_ZERO_BYPASS_EN: pairs with a zero operand
// are answered locally (gcd = A|B) without visiting the GCD unit.
module gcd_client #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_val,
  output logic         cmd_rdy,
  input  logic [W-1:0] cmd_A,
  input  logic [W-1:0] cmd_B,
  output logic         operands_val,
  input  logic         operands_rdy,
  output logic [W-1:0] operands_bits_A,
  output logic [W-1:0] operands_bits_B,
  input  logic         result_val,
  output logic         result_rdy,
  input  logic [W-1:0] result_bits_data,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic [W-1:0] resp_A,
  output logic [W-1:0] resp_B,
  output logic [W-1:0] resp_gcd,
  output logic         busy,
  output logic [15:0]  done_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W-1:0]  hold_a_q, hold_a_d, hold_b_q, hold_b_d, gcd_q, gcd_d;
  logic [W-1:0]  resp_a_q, resp_a_d, resp_b_q, resp_b_d, resp_gcd_q, resp_gcd_d;
  logic [15:0]   done_q, done_d;
  logic          cmd_rdy_q, cmd_rdy_d, op_val_q, op_val_d;
  logic          res_rdy_q, res_rdy_d, resp_val_q, resp_val_d, busy_q, busy_d;

  logic          push_s, pop_s, op_fire_s, res_fire_s, resp_fire_s;
  logic          bypass_s, zero_head_s;
  logic [W-1:0]  head_a_s, head_b_s;

  assign head_a_s = mem_a_q[rd_ptr_q];
  assign head_b_s = mem_b_q[rd_ptr_q];

`ifdef GCD_CLIENT_ZERO_BYPASS_EN
  assign zero_head_s = (head_a_s == {W{1'b0}}) || (head_b_s == {W{1'b0}});
`else
  assign zero_head_s = 1'b0;
`endif

  // Handshake fires and FIFO pointer/occupancy bookkeeping.
  always_comb begin
    push_s      = cmd_val && cmd_rdy_q;
    op_fire_s   = op_val_q && operands_rdy;
    res_fire_s  = res_rdy_q && result_val;
    resp_fire_s = resp_val_q && resp_rdy;
    bypass_s    = (state_q == ST_IDLE) && (count_q != CNT_ZERO) && zero_head_s;
    pop_s       = op_fire_s || bypass_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Issue FSM: next state plus operand, hold and result registers.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    gcd_d    = gcd_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE: begin
        if (bypass_s) begin
          hold_a_d = head_a_s;
          hold_b_d = head_b_s;
          gcd_d    = head_a_s | head_b_s;
          state_d  = ST_RESP;
        end else if (count_q != CNT_ZERO) begin
          op_a_d  = head_a_s;
          op_b_d  = head_b_s;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (op_fire_s) begin
          hold_a_d = op_a_q;
          hold_b_d = op_b_q;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (res_fire_s) begin
          gcd_d   = result_bits_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_fire_s) begin
          done_d  = done_q + 16'd1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered handshake/status outputs; response data refreshes only on RESP entry.
  always_comb begin
    op_val_d   = (state_d == ST_SEND);
    res_rdy_d  = (state_d == ST_WAIT);
    resp_val_d = (state_d == ST_RESP);
    busy_d     = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
    cmd_rdy_d  = (count_d != CNT_FULL);
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      resp_a_d   = hold_a_d;
      resp_b_d   = hold_b_d;
      resp_gcd_d = gcd_d;
    end else begin
      resp_a_d   = resp_a_q;
      resp_b_d   = resp_b_q;
      resp_gcd_d = resp_gcd_q;
    end
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= CNT_ZERO;
      op_a_q     <= {W{1'b0}};
      op_b_q     <= {W{1'b0}};
      hold_a_q   <= {W{1'b0}};
      hold_b_q   <= {W{1'b0}};
      gcd_q      <= {W{1'b0}};
      resp_a_q   <= {W{1'b0}};
      resp_b_q   <= {W{1'b0}};
      resp_gcd_q <= {W{1'b0}};
      done_q     <= 16'd0;
      cmd_rdy_q  <= 1'b1;
      op_val_q   <= 1'b0;
      res_rdy_q  <= 1'b0;
      resp_val_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      gcd_q      <= gcd_d;
      resp_a_q   <= resp_a_d;
      resp_b_q   <= resp_b_d;
      resp_gcd_q <= resp_gcd_d;
      done_q     <= done_d;
      cmd_rdy_q  <= cmd_rdy_d;
      op_val_q   <= op_val_d;
      res_rdy_q  <= res_rdy_d;
      resp_val_q <= resp_val_d;
      busy_q     <= busy_d;
    end
  end

  // Command FIFO storage: cleared on reset, written at the tail on enqueue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i] <= {W{1'b0}};
        mem_b_q[i] <= {W{1'b0}};
      end
    end else if (push_s) begin
      mem_a_q[wr_ptr_q] <= cmd_A;
      mem_b_q[wr_ptr_q] <= cmd_B;
    end
  end

  assign cmd_rdy         = cmd_rdy_q;
  assign operands_val    = op_val_q;
  assign operands_bits_A = op_a_q;
  assign operands_bits_B = op_b_q;
  assign result_rdy      = res_rdy_q;
  assign resp_val        = resp_val_q;
  assign resp_A          = resp_a_q;
  assign resp_B          = resp_b_q;
  assign resp_gcd        = resp_gcd_q;
  assign busy            = busy_q;
  assign done_count      = done_q;

endmodule

// File: tb/tb_gcd_client.sv
// Self-checking bench for gcd_client: behavioural GCD unit, host-side
// scoreboard of expected responses, table vectors, corner sequences and
// randomized traffic.
module tb_gcd_client;
  localparam int W = 16;

  logic         clk, reset;
  logic         cmd_val, cmd_rdy;
  logic [W-1:0] cmd_A, cmd_B;
  logic         operands_val, operands_rdy;
  logic [W-1:0] operands_bits_A, operands_bits_B;
  logic         result_val, result_rdy;
  logic [W-1:0] result_bits_data;
  logic         resp_val, resp_rdy;
  logic [W-1:0] resp_A, resp_B, resp_gcd;
  logic         busy;
  logic [15:0]  done_count;

  gcd_client #(.W(W), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_A(cmd_A), .cmd_B(cmd_B),
    .operands_val(operands_val), .operands_rdy(operands_rdy),
    .operands_bits_A(operands_bits_A), .operands_bits_B(operands_bits_B),
    .result_val(result_val), .result_rdy(result_rdy), .result_bits_data(result_bits_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_A(resp_A), .resp_B(resp_B), .resp_gcd(resp_gcd),
    .busy(busy), .done_count(done_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] g; } rsp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] g; int lat; } vec_t;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  rsp_t snd_q[$];
  bit   stall = 1'b0, rand_stall = 1'b0, spur = 1'b0, rand_host = 1'b0;
  int   u_lat = 1;
  int   resp_total = 0;
  int   done_exp = 0;
  int   op_val_seen = 0;
  logic [W-1:0] last_a = '0, last_b = '0, last_g = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Euclid's algorithm on plain integers.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  // Behavioural GCD unit: one problem at a time, result after u_lat cycles.
  initial begin
    bit u_busy = 1'b0, pend_op = 1'b0, pend_res = 1'b0, pv = 1'b0;
    int u_cnt = 0;
    logic [W-1:0] u_res = '0, p_a = '0, p_b = '0;
    operands_rdy = 1'b0;
    result_val = 1'b0;
    result_bits_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        u_busy = 1'b0;
        operands_rdy = 1'b0;
        result_val = 1'b0;
        result_bits_data = '0;
      end else begin
        if (pend_res) u_busy = 1'b0;
        if (pend_op) begin
          u_busy = 1'b1;
          u_cnt = u_lat;
          u_res = ref_gcd(p_a, p_b);
        end
        if (u_busy) begin
          operands_rdy = 1'b0;
          if (u_cnt > 0) begin
            u_cnt--;
            result_val = 1'b0;
          end else begin
            result_val = 1'b1;
            result_bits_data = u_res;
          end
        end else begin
          operands_rdy = stall ? 1'b0 : (rand_stall ? 1'($urandom_range(0, 1)) : 1'b1);
          result_val = spur;
          result_bits_data = spur ? 16'hDEAD : 16'h0000;
        end
      end
      #1;
      if (reset) begin
        pend_op = 1'b0;
        pend_res = 1'b0;
        pv = 1'b0;
      end else begin
        if (operands_val) op_val_seen++;
        if (pv && !pend_op && operands_val) begin
          check("op_A_stable", operands_bits_A, p_a);
          check("op_B_stable", operands_bits_B, p_b);
        end
        pend_op  = operands_val && operands_rdy;
        pend_res = result_val && result_rdy;
        pv  = operands_val;
        p_a = operands_bits_A;
        p_b = operands_bits_B;
        if (pend_op) begin
          if (snd_q.size() == 0) begin
            check("op_unexpected", 32'd1, 32'd0);
          end else begin
            rsp_t s;
            s = snd_q.pop_front();
            check("op_A_order", operands_bits_A, s.a);
            check("op_B_order", operands_bits_B, s.b);
          end
        end
      end
    end
  end

  // Host response monitor: compares each fired response with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && resp_val && resp_rdy) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("resp_A", resp_A, e.a);
          check("resp_B", resp_B, e.b);
          check("resp_gcd", resp_gcd, e.g);
        end
        last_a = resp_A;
        last_b = resp_B;
        last_g = resp_gcd;
        resp_total++;
        done_exp++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int budget, output bit ok);
    rsp_t e;
    ok = 1'b0;
    cmd_val = 1'b1;
    cmd_A = a;
    cmd_B = b;
    for (int i = 0; i < budget; i++) begin
      if (rand_host) resp_rdy = 1'($urandom_range(0, 1));
      if (cmd_rdy) begin
        ok = 1'b1;
        e.a = a; e.b = b; e.g = ref_gcd(a, b);
        exp_q.push_back(e);
`ifdef GCD_CLIENT_ZERO_BYPASS_EN
        if (a != '0 && b != '0) snd_q.push_back(e);
`else
        snd_q.push_back(e);
`endif
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    cmd_val = 1'b0;
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    int n = 0;
    while (resp_total < target && n < budget) begin
      if (rand_host) resp_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check(name, 32'(resp_total >= target), 32'd1);
  endtask

  initial begin
    vec_t tbl[10];
    bit ok;
    int base, n, seen0;
    logic [W-1:0] ea[5], eb[5];
    tbl[0] = '{16'd27,    16'd15,  16'd3,   1};
    tbl[1] = '{16'd12,    16'd8,   16'd4,   0};
    tbl[2] = '{16'd49,    16'd14,  16'd7,   3};
    tbl[3] = '{16'd9,     16'd6,   16'd3,   2};
    tbl[4] = '{16'd100,   16'd75,  16'd25,  5};
    tbl[5] = '{16'd17,    16'd5,   16'd1,   1};
    tbl[6] = '{16'd0,     16'd42,  16'd42,  2};
    tbl[7] = '{16'd0,     16'd0,   16'd0,   1};
    tbl[8] = '{16'd65535, 16'd255, 16'd255, 4};
    tbl[9] = '{16'd48,    16'd0,   16'd48,  0};
    ea = '{16'd12, 16'd49, 16'd9, 16'd6 * 16'd0 + 16'd100, 16'd17};
    eb = '{16'd8, 16'd14, 16'd6, 16'd75, 16'd5};

    reset = 1'b1; cmd_val = 1'b0; cmd_A = '0; cmd_B = '0; resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_operands_val", operands_val, 0);
    check("rst_result_rdy", result_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_busy", busy, 0);
    check("rst_done_count", done_count, 0);
    check("rst_data", {operands_bits_A, resp_gcd}, 0);

    // Table vectors, one command at a time.
    resp_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u_lat = tbl[i].lat;
      base = resp_total;
      push(tbl[i].a, tbl[i].b, 20, ok);
      check("tbl_push", ok, 1);
      wait_resp(base + 1, 40, "tbl_resp_timeout");
      check("tbl_A", last_a, tbl[i].a);
      check("tbl_B", last_b, tbl[i].b);
      check("tbl_gcd", last_g, tbl[i].g);
      check("tbl_done_count", done_count, 32'(i + 1));
      repeat (2) @(negedge clk);
      check("tbl_resp_hold", resp_gcd, tbl[i].g);
    end

    // FIFO fill against a stalled unit, then in-order drain.
    stall = 1'b1;
    u_lat = 2;
    base = resp_total;
    for (int i = 0; i < 4; i++) begin
      push(ea[i], eb[i], 10, ok);
      check("fifo_accept", ok, 1);
    end
    check("fifo_full_cmd_rdy", cmd_rdy, 0);
    push(ea[4], eb[4], 6, ok);
    check("fifo_fifth_blocked", ok, 0);
    stall = 1'b0;
    push(ea[4], eb[4], 60, ok);
    check("fifo_fifth_accept", ok, 1);
    wait_resp(base + 5, 200, "fifo_drain_timeout");
    check("fifo_last_gcd", last_g, 1);

    // Host backpressure while a response is pending.
    resp_rdy = 1'b0;
    u_lat = 1;
    base = resp_total;
    push(16'd6, 16'd4, 10, ok);
    push(16'd10, 16'd15, 10, ok);
    n = 0;
    while (!resp_val && n < 30) begin @(negedge clk); n++; end
    check("bp_resp_val_seen", resp_val, 1);
    seen0 = op_val_seen;
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_val", resp_val, 1);
      check("bp_resp_data", {resp_A, resp_B}, {16'd6, 16'd4});
      check("bp_resp_gcd", resp_gcd, 2);
      check("bp_result_rdy", result_rdy, 0);
      @(negedge clk);
    end
    check("bp_no_operands", op_val_seen, seen0);
    resp_rdy = 1'b1;
    wait_resp(base + 2, 40, "bp_release_timeout");
    check("bp_second_gcd", last_g, 5);

    // Spurious result_val while the client is still sending.
    stall = 1'b1;
    spur = 1'b1;
    base = resp_total;
    push(16'd27, 16'd15, 10, ok);
    n = 0;
    while (!operands_val && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      check("spur_result_rdy", result_rdy, 0);
      @(negedge clk);
    end
    spur = 1'b0;
    @(negedge clk);
    stall = 1'b0;
    wait_resp(base + 1, 40, "spur_resp_timeout");
    check("spur_gcd", last_g, 3);

    // Reset while waiting on the unit with two commands queued.
    u_lat = 50;
    push(16'd21, 16'd14, 10, ok);
    push(16'd8, 16'd4, 10, ok);
    push(16'd9, 16'd3, 10, ok);
    n = 0;
    while (!result_rdy && n < 20) begin @(negedge clk); n++; end
    check("rst_in_wait_reached", result_rdy, 1);
    reset = 1'b1;
    exp_q.delete();
    snd_q.delete();
    @(negedge clk);
    reset = 1'b0;
    done_exp = 0;
    check("midrst_busy", busy, 0);
    check("midrst_valids", {operands_val, result_rdy, resp_val}, 0);
    check("midrst_done_count", done_count, 0);
    check("midrst_cmd_rdy", cmd_rdy, 1);
    base = resp_total;
    repeat (60) @(negedge clk);
    check("midrst_no_resp", resp_total, base);
    check("midrst_idle", busy, 0);

    // Zero operand pair.
    u_lat = 1;
    seen0 = op_val_seen;
    push(16'd0, 16'd42, 10, ok);
    wait_resp(base + 1, 40, "zero_resp_timeout");
    check("zero_gcd", last_g, 42);
`ifdef GCD_CLIENT_ZERO_BYPASS_EN
    check("zero_no_operands", op_val_seen, seen0);
`else
    check("zero_sent_to_unit", 32'(op_val_seen > seen0), 1);
`endif

    // Randomized traffic with random stalls and host backpressure.
    rand_stall = 1'b1;
    rand_host = 1'b1;
    base = resp_total;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] g, a, b;
      g = 16'($urandom_range(1, 20));
      a = g * 16'($urandom_range(0, 50));
      b = g * 16'($urandom_range(0, 50));
      u_lat = $urandom_range(0, 4);
      push(a, b, 200, ok);
      check("rand_push", ok, 1);
      if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
    end
    wait_resp(base + 40, 2000, "rand_drain_timeout");
    rand_host = 1'b0;
    rand_stall = 1'b0;
    resp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("final_done_count", done_count, 32'(done_exp));
    check("final_busy", busy, 0);
    check("final_cmd_rdy", cmd_rdy, 1);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
